// File: rtl/seq_signed_div32.sv
// Signed 32/32 restoring divider: quotient truncated toward zero, remainder takes the dividend's sign.
// Latency: done 35 cycles after the accepted start (2 cycles for B==0 when SEQ_DIV_DZ_TRAP_EN is defined).
// Backpressure: start is ignored while busy; Q/R/ovf/dz hold until the next operation completes.
module seq_signed_div32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Q,
  output logic [31:0] R,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic        dz
);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t      state;
  logic [31:0] a_q, b_q;
  logic        sa, sb;
  logic [31:0] dvd;
  logic [31:0] mag_b;
  logic [31:0] rem;
  logic [4:0]  cnt;
  logic [32:0] shifted, trial;

  function automatic logic [31:0] neg(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  // rem < |B| <= 2^31 keeps the shifted remainder within 33 bits
  always_comb begin
    shifted = {rem, dvd[31]};
    trial   = shifted - {1'b0, mag_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      dvd   <= '0;
      mag_b <= '0;
      rem   <= '0;
      cnt   <= '0;
      Q     <= '0;
      R     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      dz    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            sa    <= A[31];
            sb    <= B[31];
            busy  <= 1'b1;
            state <= PREP;
          end
        end
        PREP: begin
`ifdef SEQ_DIV_DZ_TRAP_EN
          if (b_q == 32'd0) begin
            Q     <= 32'hFFFF_FFFF;
            R     <= a_q;
            dz    <= 1'b1;
            ovf   <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else
`endif
          begin
            dvd   <= sa ? neg(a_q) : a_q;
            mag_b <= sb ? neg(b_q) : b_q;
            rem   <= '0;
            cnt   <= 5'd31;
            state <= ITER;
          end
        end
        ITER: begin
          // dvd shifts the dividend out at the top and the quotient in at the bottom
          dvd <= {dvd[30:0], ~trial[32]};
          rem <= trial[32] ? shifted[31:0] : trial[31:0];
          if (cnt == 5'd0) state <= FIX;
          else             cnt   <= cnt - 5'd1;
        end
        FIX: begin
          Q     <= (sa ^ sb) ? neg(dvd) : dvd;
          R     <= sa ? neg(rem) : rem;
          ovf   <= (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
          dz    <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
